// File: rtl/comparator.sv
//------------------------------------------------------------------------------
// Module   : comparator
// Purpose  : Registered signed compare of two WIDTH-bit operands (ZERO / SIGN).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module comparator #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] OP1,
    input  logic [WIDTH-1:0] OP2,
    output logic             ZERO,
    output logic             SIGN
);

    logic [WIDTH:0] diff_w;
    logic           zero_d;
    logic           sign_d;
    logic           zero_q;
    logic           sign_q;

    // One extra bit of headroom keeps the difference sign correct on overflow.
    assign diff_w = {OP1[WIDTH-1], OP1} - {OP2[WIDTH-1], OP2};
    assign zero_d = (OP1 == OP2);
    assign sign_d = diff_w[WIDTH];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            zero_q <= 1'b0;
            sign_q <= 1'b0;
        end else begin
            zero_q <= zero_d;
            sign_q <= sign_d;
        end
    end

    assign ZERO = zero_q;
    assign SIGN = sign_q;

endmodule

`default_nettype wire

// File: tb/tb_comparator.sv
//------------------------------------------------------------------------------
// Module   : tb_comparator
// Purpose  : Scoreboard bench for comparator: driver queues expectations, monitor checks.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_comparator;

    localparam int W = 16;

    typedef struct {
        logic  ez;
        logic  es;
        string nm;
    } exp_t;

    logic         CLK;
    logic         RST_N;
    logic [W-1:0] OP1;
    logic [W-1:0] OP2;
    logic         ZERO;
    logic         SIGN;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    comparator #(.WIDTH(W)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .OP1   (OP1),
        .OP2   (OP2),
        .ZERO  (ZERO),
        .SIGN  (SIGN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got ZERO/SIGN=%b required %b at %0t", nm, act, req, $time);
        end
    endtask

    task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b, input logic rn,
                         input logic ez, input logic es, input string nm);
        exp_t e;
        @(negedge CLK);
        OP1   = a;
        OP2   = b;
        RST_N = rn;
        e.ez  = ez;
        e.es  = es;
        e.nm  = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge presents a result; pop and compare when one is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.nm, {ZERO, SIGN}, {e.ez, e.es});
                chk("exclusive", {1'b0, ZERO & SIGN}, 2'b00);
            end
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           waited;
        n_cmp = 0;
        n_bad = 0;
        RST_N = 1'b0;
        OP1   = '0;
        OP2   = '0;

        apply(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "reset1");
        apply(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, "reset2");
        apply(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, "release");
        apply(16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0, "1_vs_0");
        apply(16'h0000, 16'h0001, 1'b1, 1'b0, 1'b1, "0_vs_1");
        apply(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, "ovf_8000_0001");
        apply(16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 1'b0, "ovf_7FFF_FFFF");
        apply(16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0, "eq_8000");
        apply(16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, "max_vs_min");
        apply(16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1, "min_vs_max");
        apply(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, "eq_FFFF");
        apply(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, "m1_vs_0");

        // Reset glitch between edges must not disturb the held result (0/1).
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        chk("async_glitch", {ZERO, SIGN}, 2'b01);
        RST_N = 1'b1;

        apply(16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, "pre_midrst");
        apply(16'h1234, 16'h1235, 1'b0, 1'b0, 1'b0, "midrst");
        apply(16'h1234, 16'h1234, 1'b1, 1'b1, 1'b0, "post_midrst");
        apply(16'h0005, 16'hFFFB, 1'b1, 1'b0, 1'b0, "5_vs_m5");
        apply(16'hFFFB, 16'h0005, 1'b1, 1'b0, 1'b1, "m5_vs_5");

        for (int i = 0; i < 10000; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            if ($urandom_range(0, 7) == 0) b = a;
            if (i == 5000)
                apply(a, b, 1'b0, 1'b0, 1'b0, "rand_rst");
            else
                apply(a, b, 1'b1, (a == b), ($signed(a) < $signed(b)), "rand");
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge CLK);
            #2;
            waited++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d results pending, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
